mem_port: RTL

//  Memory-side stage directly downstream of the multicycle controller FSM. It turns the
//  FSM's one-cycle memory strobes (IRWrite fetch, MemRead data read, MemWrite store) into
//  a req/ack transaction on a variable-latency unified memory, and raises stall so the
//  FSM and PC hold while the access is outstanding. It also owns the Instruction Register
//  and Memory Data Register. Datapath gates PCWrite/RegWrite/state update with !stall.

---
 rtl/mem_port_if.sv | 40 ++++
 rtl/mem_port.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mem_port_if.sv
// ============================================================================
// Module      : mem_port_if
// Description : Request/acknowledge bus between mem_port and a
//               variable-latency unified memory.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   mem_req   : memory request, held until mem_ack
//   mem_we    : 1 = write transaction
//   mem_addr  : transaction address, stable while mem_req
//   mem_wdata : write data, stable while mem_req
//   mem_rdata : read data, valid in the mem_ack cycle
//   mem_ack   : one-cycle completion pulse
// Modports: master (mem_port side), slave (memory side)
// ============================================================================
`default_nettype none

interface mem_port_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

`default_nettype wire

// File: rtl/mem_port.sv
// ============================================================================
// Module      : mem_port
// Description : Memory-side stage behind the multicycle controller FSM.
//               Converts one-cycle fetch/read/store strobes into a req/ack
//               transaction, stalls the FSM while the access is
//               outstanding, and owns the Instruction and Memory Data
//               Registers.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   IorD                : address select (0 = pc, 1 = alu_out)
//   IRWrite/MemRead/MemWrite : FSM fetch / data-read / store strobes
//   pc, alu_out, wd     : address sources and store data
//   stall               : combinational FSM/PC hold request
//   instr, mdr          : Instruction Register, Memory Data Register
//   err                 : sticky error (timeout, strobe conflict, stray ack)
//   mem                 : memory bus (mem_port_if.master)
//   stall_count         : stall-cycle counter (only with MEM_PORT_PERF_EN)
// Configuration macro: MEM_PORT_PERF_EN adds the saturating stall_count
// output; when undefined the port and counter are absent.
// ============================================================================
`default_nettype none

module mem_port #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IorD,
  input  logic              IRWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wd,
  output logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] mdr,
  output logic              err,
  mem_port_if.master        mem
`ifdef MEM_PORT_PERF_EN
  ,
  output logic [31:0]       stall_count
`endif
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  typedef enum logic [1:0] {K_FETCH = 2'd0, K_READ = 2'd1, K_WRITE = 2'd2} kind_t;

  localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

  state_t      state, state_next;
  kind_t       kind;
  logic [15:0] timer;
  logic        strobe, conflict;
  logic        start, done, abort;

  assign mem.mem_req = (state == BUSY);

  always_comb begin
    strobe     = IRWrite | MemRead | MemWrite;
    conflict   = (IRWrite & MemRead) | (IRWrite & MemWrite) | (MemRead & MemWrite);
    state_next = state;
    stall      = 1'b0;
    start      = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (strobe) begin
          start      = 1'b1;
          stall      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // An ack in the final timer cycle still completes normally.
        if (mem.mem_ack) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if (timer == TLAST) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else begin
          stall      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      kind          <= K_FETCH;
      timer         <= '0;
      instr         <= '0;
      mdr           <= '0;
      err           <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        mem.mem_addr  <= IorD ? alu_out : pc;
        mem.mem_we    <= MemWrite;
        mem.mem_wdata <= wd;
        kind          <= MemWrite ? K_WRITE : (MemRead ? K_READ : K_FETCH);
        timer         <= '0;
        if (conflict) err <= 1'b1;
      end
      if (state == BUSY && !mem.mem_ack) timer <= timer + 16'd1;
      if (done) begin
        mem.mem_we <= 1'b0;
        case (kind)
          K_FETCH: instr <= mem.mem_rdata;
          K_READ:  mdr   <= mem.mem_rdata;
          default: ;
        endcase
      end
      if (abort) begin
        mem.mem_we <= 1'b0;
        err        <= 1'b1;
      end
      // Acks with no transaction outstanding are stray (e.g. after a reset abort).
      if (state == IDLE && mem.mem_ack) err <= 1'b1;
    end
  end

`ifdef MEM_PORT_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (stall && stall_count != 32'hFFFF_FFFF) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire
